// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the multiplexed 7-segment scan
// controller. Segment codes are active-low {a,b,c,d,e,f,g}, with bit 6 = a.
package disp_pkg;

   localparam logic [6:0] SEG_0   = 7'b0000001;
   localparam logic [6:0] SEG_1   = 7'b1001111;
   localparam logic [6:0] SEG_2   = 7'b0010010;
   localparam logic [6:0] SEG_3   = 7'b0000110;
   localparam logic [6:0] SEG_4   = 7'b1001100;
   localparam logic [6:0] SEG_5   = 7'b0100100;
   localparam logic [6:0] SEG_6   = 7'b0100000;
   localparam logic [6:0] SEG_7   = 7'b0001111;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0000100;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b1100000;
   localparam logic [6:0] SEG_C   = 7'b0110001;
   localparam logic [6:0] SEG_D   = 7'b1000010;
   localparam logic [6:0] SEG_E   = 7'b0110000;
   localparam logic [6:0] SEG_F   = 7'b0111000;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic       DP_OFF  = 1'b1;

   // Bits needed to hold 0..value-1; never less than 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) r = 32'(i + 1);
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/disp_seg_dec.sv
// disp_seg_dec: combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble_i  4-bit value 0..F
//   seg_c_o   segments {a,b,c,d,e,f,g}, bit 6 = a, low = lit
module disp_seg_dec
   import disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_c_o
);

   always_comb begin
      seg_c_o = SEG_OFF;
      unique case (nibble_i)
         4'h0: seg_c_o = SEG_0;
         4'h1: seg_c_o = SEG_1;
         4'h2: seg_c_o = SEG_2;
         4'h3: seg_c_o = SEG_3;
         4'h4: seg_c_o = SEG_4;
         4'h5: seg_c_o = SEG_5;
         4'h6: seg_c_o = SEG_6;
         4'h7: seg_c_o = SEG_7;
         4'h8: seg_c_o = SEG_8;
         4'h9: seg_c_o = SEG_9;
         4'hA: seg_c_o = SEG_A;
         4'hB: seg_c_o = SEG_B;
         4'hC: seg_c_o = SEG_C;
         4'hD: seg_c_o = SEG_D;
         4'hE: seg_c_o = SEG_E;
         4'hF: seg_c_o = SEG_F;
         default: seg_c_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed common-anode 7-segment scan controller.
// Scans DIGITS digits from leftmost (DIGITS-1) to digit 0, one slot of
// SCAN_COUNT clocks each, using a clock-enable tick (no derived clock).
// Display contents come from shadow registers refreshed once per frame.
// Optional feature: define DISP_PWM_EN to gate the digit select with a
// 4-bit PWM compare against bright; otherwise bright is ignored.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   en          scan enable; low blanks outputs and freezes scanning
//   data        nibble per digit, nibble k = data[4k+3:4k]
//   dp          decimal point request per digit, 1 = lit
//   blank       force digit dark, 1 = dark
//   lzb         leading-zero blanking enable
//   bright      PWM brightness (DISP_PWM_EN builds only)
//   sel         digit select, active-low, one-cold
//   m_disp      segments {a..g}, active-low
//   m_dp        decimal-point segment, active-low
//   frame_done  one-cycle pulse after the digit 0 slot ends
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned SCAN_COUNT = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lzb,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     sel,
   output logic [6:0]            m_disp,
   output logic                  m_dp,
   output logic                  frame_done
);

   localparam int unsigned IDX_W  = clog2(DIGITS);
   localparam int unsigned CNT_W  = clog2(SCAN_COUNT);
   localparam int unsigned DATA_W = 4 * DIGITS;

   if (SCAN_COUNT < 16) begin : g_bad_scan_count
      $error("disp_scan_ctrl: SCAN_COUNT must be >= 16");
   end
   if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
      $error("disp_scan_ctrl: DIGITS must be in 2..8");
   end

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] sh_data_q;
   logic [DIGITS-1:0] sh_dp_q, sh_blank_q;
   logic              sh_lzb_q;
   logic              cap_init_q;

   logic [DIGITS-1:0] sel_q, sel_d;
   logic [6:0]        disp_q, disp_d;
   logic              dp_q, dp_d;
   logic              fd_q, fd_d;

   logic              tick_c, last_c, capture_c, dark_c, pwm_on_c;
   logic [DIGITS-1:0] lz_c;
   logic [3:0]        nib_c;
   logic [6:0]        seg_c;

   assign tick_c    = en && (cnt_q == CNT_W'(SCAN_COUNT - 1));
   assign last_c    = (idx_q == '0);
   // First clock after reset release, then once per frame at the end of digit 0.
   assign capture_c = cap_init_q | (tick_c & last_c);

`ifdef DISP_PWM_EN
   logic [3:0] pwm_q;

   // Free-running duty counter; only advances while scanning.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_q <= 4'h0;
      end else if (en) begin
         pwm_q <= pwm_q + 4'h1;
      end
   end

   assign pwm_on_c = (pwm_q <= bright);
`else
   logic unused_bright_c;
   assign unused_bright_c = ^bright;
   assign pwm_on_c        = 1'b1;
`endif

   // Prescaler and digit index advance.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (en) begin
         cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
      end
      if (tick_c) begin
         idx_d = last_c ? IDX_W'(DIGITS - 1) : idx_q - IDX_W'(1);
      end
   end

   // A digit is LZ-dark while it and every digit to its left hold zero.
   always_comb begin
      logic zrun;
      lz_c = '0;
      zrun = sh_lzb_q;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zrun    = zrun & (sh_data_q[4*k +: 4] == 4'h0);
         lz_c[k] = zrun;
      end
   end

   assign nib_c  = sh_data_q[4*idx_q +: 4];
   assign dark_c = sh_blank_q[idx_q] | lz_c[idx_q];

   disp_seg_dec u_seg_dec (
      .nibble_i (nib_c),
      .seg_c_o  (seg_c)
   );

   // Next output values from the current idx/cnt/shadow state.
   always_comb begin
      sel_d  = '1;
      disp_d = SEG_OFF;
      dp_d   = DP_OFF;
      fd_d   = 1'b0;
      if (en) begin
         if (pwm_on_c) sel_d = ~(DIGITS'(1) << idx_q);
         disp_d = dark_c ? SEG_OFF : seg_c;
         dp_d   = dark_c ? DP_OFF : ~sh_dp_q[idx_q];
         fd_d   = tick_c & last_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         idx_q      <= IDX_W'(DIGITS - 1);
         sh_data_q  <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
         sh_lzb_q   <= 1'b0;
         cap_init_q <= 1'b1;
         sel_q      <= '1;
         disp_q     <= SEG_OFF;
         dp_q       <= DP_OFF;
         fd_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cap_init_q <= 1'b0;
         if (capture_c) begin
            sh_data_q  <= data;
            sh_dp_q    <= dp;
            sh_blank_q <= blank;
            sh_lzb_q   <= lzb;
         end
         sel_q  <= sel_d;
         disp_q <= disp_d;
         dp_q   <= dp_d;
         fd_q   <= fd_d;
      end
   end

   assign sel        = sel_q;
   assign m_disp     = disp_q;
   assign m_dp       = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: self-checking bench for disp_scan_ctrl (DIGITS=4,
// SCAN_COUNT=16). The reference model tracks the number of enabled cycles
// since reset and derives digit, slot position and frame boundaries by
// division, with decoding from a lookup table.
module tb_disp_scan_ctrl;

   localparam int D  = 4;
   localparam int SC = 16;

   if (SC < 16) begin : g_sc_check
      $error("SCAN_COUNT below 16 is not a legal configuration");
   end

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           en = 1'b0;
   logic [4*D-1:0] data = '0;
   logic [D-1:0]   dp = '0;
   logic [D-1:0]   blank = '0;
   logic           lzb = 1'b0;
   logic [3:0]     bright = 4'hF;
   logic [D-1:0]   sel;
   logic [6:0]     m_disp;
   logic           m_dp;
   logic           frame_done;

   always #5 clk = ~clk;

   disp_scan_ctrl #(.DIGITS(D), .SCAN_COUNT(SC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .data       (data),
      .dp         (dp),
      .blank      (blank),
      .lzb        (lzb),
      .bright     (bright),
      .sel        (sel),
      .m_disp     (m_disp),
      .m_dp       (m_dp),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int             pos;
   logic           init_m;
   logic [4*D-1:0] sh_data;
   logic [D-1:0]   sh_dp, sh_blank;
   logic           sh_lzb;
   logic [D-1:0]   e_sel;
   logic [6:0]     e_disp;
   logic           e_dp, e_fd;

   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pos      = 0;
      init_m   = 1'b1;
      sh_data  = '0;
      sh_dp    = '0;
      sh_blank = '0;
      sh_lzb   = 1'b0;
      e_sel    = '1;
      e_disp   = 7'h7F;
      e_dp     = 1'b1;
      e_fd     = 1'b0;
   endtask

   task automatic capture();
      sh_data  = data;
      sh_dp    = dp;
      sh_blank = blank;
      sh_lzb   = lzb;
   endtask

   // Outputs after a clock edge, from the model state and inputs at that edge.
   task automatic model_edge();
      int   idx;
      logic dark;
      e_sel  = '1;
      e_disp = 7'h7F;
      e_dp   = 1'b1;
      e_fd   = 1'b0;
      if (en) begin
         idx  = D - 1 - ((pos / SC) % D);
         dark = sh_blank[idx];
         if (sh_lzb && idx > 0 && (sh_data >> (4 * idx)) == 0) dark = 1'b1;
         e_sel = ~(D'(1) << idx);
`ifdef DISP_PWM_EN
         if ((pos % 16) > int'(bright)) e_sel = '1;
`endif
         e_disp = dark ? 7'h7F : seg_tab[4'(sh_data >> (4 * idx))];
         e_dp   = dark ? 1'b1 : ~sh_dp[idx];
         e_fd   = ((pos % SC) == SC - 1) && (idx == 0);
      end
      if (init_m) capture();
      if (en && (pos % (SC * D)) == SC * D - 1) capture();
      if (en) pos++;
      init_m = 1'b0;
   endtask

   task automatic check_outputs(input string pfx);
      chk({pfx, "sel"}, 32'(sel), 32'(e_sel));
      chk({pfx, "m_disp"}, 32'(m_disp), 32'(e_disp));
      chk({pfx, "m_dp"}, 32'(m_dp), 32'(e_dp));
      chk({pfx, "frame_done"}, 32'(frame_done), 32'(e_fd));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_edge();
      else     model_reset();
      #1;
      check_outputs("");
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < D; k++) begin
         data[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      dp     = D'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      lzb    = 1'($urandom);
      bright = 4'($urandom);
   endtask

   initial begin
      int fd_cnt;
      model_reset();
      en   = 1'b1;
      data = 16'h1A3F;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 32'(sel), 32'hF);
      chk("rst_m_disp", 32'(m_disp), 32'h7F);
      chk("rst_m_dp", 32'(m_dp), 32'h1);
      chk("rst_frame_done", 32'(frame_done), 32'h0);

      // Basic scan with hex decode
      rst = 1'b1;
      step();
      chk("start_sel", 32'(sel), 32'h7);
      fd_cnt = 0;
      repeat (128) begin
         step();
         fd_cnt += int'(frame_done);
      end
      chk("frame_done_count", 32'(fd_cnt), 32'd2);
      repeat (64) step();

      // Leading-zero blanking
      lzb  = 1'b1;
      data = 16'h0070;
      repeat (200) step();

      // Mid-frame data change while digit 2 is being shown
      lzb  = 1'b0;
      data = 16'h1111;
      repeat (100) step();
      for (int g = 0; g < SC * D && (pos % (SC * D)) != SC + 5; g++) step();
      data = 16'h2222;
      repeat (150) step();

      // Enable dropped mid-slot for 40 cycles
      for (int g = 0; g < SC && (pos % SC) != 7; g++) step();
      en = 1'b0;
      step();
      chk("en_low_sel", 32'(sel), 32'hF);
      chk("en_low_m_disp", 32'(m_disp), 32'h7F);
      repeat (39) step();
      en = 1'b1;
      repeat (100) step();

      // Decimal points and brightness
      dp     = 4'b0100;
      bright = 4'd3;
      repeat (140) step();
      bright = 4'd15;
      repeat (70) step();

      // Randomized traffic
      repeat (3000) begin
         if ($urandom_range(0, 9) == 0) rand_inputs();
         en = ($urandom_range(0, 19) != 0);
         step();
      end

      // Asynchronous reset mid-frame
      en = 1'b1;
      repeat (37) step();
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_sel", 32'(sel), 32'hF);
      chk("async_rst_m_disp", 32'(m_disp), 32'h7F);
      chk("async_rst_m_dp", 32'(m_dp), 32'h1);
      chk("async_rst_frame_done", 32'(frame_done), 32'h0);
      model_reset();
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("restart_sel", 32'(sel), 32'h7);

      repeat (1000) begin
         if ($urandom_range(0, 7) == 0) rand_inputs();
         en = ($urandom_range(0, 29) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
